// File: rtl/fpu_unit_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpu_seq_pkg
// Description : Shared types and constants for the FPU multi-cycle unit
//               sequencer (state encoding, unit indices, defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_seq_pkg;

  // Sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_t;

  // Attached execution unit indices
  localparam int FPU_UNIT_CLASSIFY = 0;
  localparam int FPU_UNIT_CMP      = 1;
  localparam int FPU_UNIT_CVT      = 2;
  localparam int FPU_UNIT_DIVSQRT  = 3;

  localparam int FPU_DEFAULT_NUM_UNITS = 4;
  localparam int FPU_DEFAULT_TIMEOUT   = 64;

endpackage
`default_nettype wire

// File: rtl/fpu_unit_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : fpu_unit_sequencer_if
// Description : EX-stage request, unit start/result and writeback signals of
//               the FPU multi-cycle unit sequencer. The sequencer uses the
//               slave modport; the EX stage / unit side uses master.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_unit_sequencer_if #(
  parameter int NUM_UNITS = 4
);
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic                        i_req_valid;
  logic [UW-1:0]               i_req_unit;
  logic [4:0]                  i_req_rd;
  logic                        i_req_rd_is_int;
  logic                        i_flush;
  logic [NUM_UNITS-1:0]        o_unit_start;
  logic [NUM_UNITS-1:0]        i_unit_valid;
  logic [NUM_UNITS-1:0][31:0]  i_unit_result;
  logic                        o_stall;
  logic                        o_wb_valid;
  logic [31:0]                 o_wb_data;
  logic [4:0]                  o_wb_rd;
  logic                        o_wb_is_int;
  logic                        o_error;

  modport slave (
    input  i_req_valid, i_req_unit, i_req_rd, i_req_rd_is_int, i_flush,
    input  i_unit_valid, i_unit_result,
    output o_unit_start, o_stall, o_wb_valid, o_wb_data, o_wb_rd,
    output o_wb_is_int, o_error
  );

  modport master (
    output i_req_valid, i_req_unit, i_req_rd, i_req_rd_is_int, i_flush,
    output i_unit_valid, i_unit_result,
    input  o_unit_start, o_stall, o_wb_valid, o_wb_data, o_wb_rd,
    input  o_wb_is_int, o_error
  );

endinterface
`default_nettype wire

// File: rtl/fpu_unit_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : fpu_seq_watchdog
// Description : Hung-unit watchdog. Counter clears on i_clear, counts while
//               enabled and flags expiry at TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  input  wire logic i_clear,
  input  wire logic i_enable,
  output logic      o_expired
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] c_limit = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count cycles spent waiting; hold at the limit once reached
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/fpu_unit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_unit_sequencer
// Description : Issue/completion sequencer for the EX-stage multi-cycle FP
//               units. One op in flight; start pulse, stall until result,
//               one registered writeback; flush and watchdog handling.
// Revision    : 1.0 - initial release
// ============================================================================
import fpu_seq_pkg::*;

module fpu_unit_sequencer #(
  parameter int NUM_UNITS      = FPU_DEFAULT_NUM_UNITS,
  parameter int TIMEOUT_CYCLES = FPU_DEFAULT_TIMEOUT
) (
  input wire logic            i_clk,
  input wire logic            i_rst,
  fpu_unit_sequencer_if.slave bus
);
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [UW:0] c_num_units = (UW + 1)'(NUM_UNITS);

  seq_state_t    r_state;
  logic [UW-1:0] r_unit;
  logic [4:0]    r_rd;
  logic          r_is_int;
  logic [31:0]   r_result;
  logic          r_error;

  logic w_accept;
  logic w_bad_unit;
  logic w_sel_valid;
  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  assign w_accept    = (r_state == ST_IDLE) && bus.i_req_valid && !bus.i_flush;
  assign w_bad_unit  = {1'b0, bus.i_req_unit} >= c_num_units;
  // Only the selected unit's valid matters; the others are ignored
  assign w_sel_valid = bus.i_unit_valid[r_unit];

  // Counter restarts whenever WAIT or DRAIN is entered
  assign w_wd_clear  = (r_state == ST_ISSUE) ||
                       ((r_state == ST_WAIT) && bus.i_flush && !w_sel_valid);
  assign w_wd_enable = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

  fpu_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  // Sequencer FSM with registered error pulse and latched op fields
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_unit   <= '0;
      r_rd     <= '0;
      r_is_int <= 1'b0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_bad_unit) begin
              r_error <= 1'b1;
            end else begin
              r_unit   <= bus.i_req_unit;
              r_rd     <= bus.i_req_rd;
              r_is_int <= bus.i_req_rd_is_int;
              r_state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= bus.i_flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (w_sel_valid) begin
            if (bus.i_flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_result <= bus.i_unit_result[r_unit];
              r_state  <= ST_WB;
            end
          end else if (bus.i_flush) begin
            r_state <= ST_DRAIN;
          end else if (w_wd_expired) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          // Unit cannot be cancelled: swallow its result when it arrives
          if (w_sel_valid) begin
            r_state <= ST_IDLE;
          end else if (w_wd_expired) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // One-hot start pulse decoded from the ISSUE state and latched unit
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_start
    assign bus.o_unit_start[gi] = (r_state == ST_ISSUE) && (r_unit == UW'(gi));
  end

  // A flush arriving during WB squashes the op, so the valid is masked
  assign bus.o_wb_valid  = (r_state == ST_WB) && !bus.i_flush;
  assign bus.o_wb_data   = r_result;
  assign bus.o_wb_rd     = r_rd;
  assign bus.o_wb_is_int = r_is_int;
  assign bus.o_error     = r_error;
  assign bus.o_stall     = w_accept || (r_state == ST_ISSUE) ||
                           (r_state == ST_WAIT) || (r_state == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_fpu_unit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_unit_sequencer
// Description : Self-checking bench for fpu_unit_sequencer. Main instance
//               (4 units, timeout 64) and a second instance (3 units,
//               timeout 8) for out-of-range index and watchdog cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_unit_sequencer;

  logic clk;
  logic rst;

  fpu_unit_sequencer_if #(.NUM_UNITS(4)) b1 ();
  fpu_unit_sequencer_if #(.NUM_UNITS(3)) b2 ();

  fpu_unit_sequencer #(.NUM_UNITS(4), .TIMEOUT_CYCLES(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b1.slave)
  );

  fpu_unit_sequencer #(.NUM_UNITS(3), .TIMEOUT_CYCLES(8)) dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        req_valid;
    logic [1:0]  unit;
    logic [4:0]  rd;
    logic        is_int;
    logic        flush;
    logic [3:0]  uvalid;
    logic [1:0]  rl;
    logic [31:0] res;
    logic [3:0]  e_start;
    logic        e_stall;
    logic        e_wb;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_int;
    logic        e_err;
  } vec_t;

  localparam int NV = 26;
  vec_t tv [NV];

  function automatic vec_t mk(logic rv, logic [1:0] u, logic [4:0] rd, logic ii,
                              logic fl, logic [3:0] uv, logic [1:0] rl,
                              logic [31:0] res, logic [3:0] es, logic est,
                              logic ewb, logic [31:0] ed, logic [4:0] erd,
                              logic eint, logic eerr);
    vec_t v;
    v.req_valid = rv; v.unit = u; v.rd = rd; v.is_int = ii; v.flush = fl;
    v.uvalid = uv; v.rl = rl; v.res = res; v.e_start = es; v.e_stall = est;
    v.e_wb = ewb; v.e_data = ed; v.e_rd = erd; v.e_int = eint; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    b1.i_req_valid = 1'b0; b1.i_req_unit = '0; b1.i_req_rd = '0;
    b1.i_req_rd_is_int = 1'b0; b1.i_flush = 1'b0; b1.i_unit_valid = '0;
    for (int i = 0; i < 4; i++) b1.i_unit_result[i] = 32'hDEAD_0000 | 32'(i);
  endtask

  task automatic idle2();
    b2.i_req_valid = 1'b0; b2.i_req_unit = '0; b2.i_req_rd = '0;
    b2.i_req_rd_is_int = 1'b0; b2.i_flush = 1'b0; b2.i_unit_valid = '0;
    for (int i = 0; i < 3; i++) b2.i_unit_result[i] = 32'hBEEF_0000 | 32'(i);
  endtask

  task automatic req1(input logic [1:0] u, input logic [4:0] rd, input logic ii);
    b1.i_req_valid = 1'b1; b1.i_req_unit = u; b1.i_req_rd = rd; b1.i_req_rd_is_int = ii;
  endtask

  task automatic chk_all1(input string nm, input logic [3:0] es, input logic est,
                          input logic ewb, input logic eerr);
    chk({nm, " start"}, 32'(b1.o_unit_start), 32'(es));
    chk({nm, " stall"}, 32'(b1.o_stall), 32'(est));
    chk({nm, " wb_valid"}, 32'(b1.o_wb_valid), 32'(ewb));
    chk({nm, " error"}, 32'(b1.o_error), 32'(eerr));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    //          rv u  rd  ii fl uvalid   rl  res           start   st wb data        rd  ii err
    tv[0]  = mk(1, 0, 10, 1, 0, 4'b0000, 0, 32'h0,        4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[1]  = mk(1, 0, 10, 1, 0, 4'b0000, 0, 32'h0,        4'b0001, 1, 0, 32'h0,      0,  0, 0);
    tv[2]  = mk(1, 0, 10, 1, 0, 4'b0001, 0, 32'h200,      4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[3]  = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 0, 1, 32'h200,    10, 1, 0);
    tv[4]  = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 32'h0,      0,  0, 0);
    tv[5]  = mk(1, 1, 3,  1, 0, 4'b0000, 0, 32'h0,        4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[6]  = mk(1, 1, 3,  1, 0, 4'b0000, 0, 32'h0,        4'b0010, 1, 0, 32'h0,      0,  0, 0);
    tv[7]  = mk(1, 1, 3,  1, 0, 4'b0100, 2, 32'h0BAD,     4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[8]  = mk(1, 1, 3,  1, 0, 4'b0010, 1, 32'h1,        4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[9]  = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 0, 1, 32'h1,      3,  1, 0);
    tv[10] = mk(1, 2, 7,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[11] = mk(1, 2, 7,  0, 0, 4'b0000, 0, 32'h0,        4'b0100, 1, 0, 32'h0,      0,  0, 0);
    tv[12] = mk(1, 2, 7,  0, 0, 4'b0100, 2, 32'h3F800000, 4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[13] = mk(0, 0, 0,  0, 1, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 32'h0,      0,  0, 0);
    tv[14] = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 32'h0,      0,  0, 0);
    tv[15] = mk(1, 0, 1,  1, 0, 4'b0000, 0, 32'h0,        4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[16] = mk(1, 0, 1,  1, 0, 4'b0000, 0, 32'h0,        4'b0001, 1, 0, 32'h0,      0,  0, 0);
    tv[17] = mk(0, 0, 0,  0, 1, 4'b0001, 0, 32'h55,       4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[18] = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 32'h0,      0,  0, 0);
    tv[19] = mk(1, 1, 2,  0, 1, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 32'h0,      0,  0, 0);
    tv[20] = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 32'h0,      0,  0, 0);
    tv[21] = mk(1, 1, 2,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[22] = mk(0, 0, 0,  0, 1, 4'b0000, 0, 32'h0,        4'b0010, 1, 0, 32'h0,      0,  0, 0);
    tv[23] = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[24] = mk(0, 0, 0,  0, 0, 4'b0010, 1, 32'h77,       4'b0000, 1, 0, 32'h0,      0,  0, 0);
    tv[25] = mk(0, 0, 0,  0, 0, 4'b0000, 0, 32'h0,        4'b0000, 0, 0, 32'h0,      0,  0, 0);

    // Reset state
    rst = 1'b1;
    idle1();
    idle2();
    step();
    step();
    @(negedge clk);
    chk_all1("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("reset wb_data", b1.o_wb_data, 32'h0);
    chk("reset wb_rd", 32'(b1.o_wb_rd), 32'h0);
    chk("reset wb_is_int", 32'(b1.o_wb_is_int), 32'h0);
    chk("reset2 start", 32'(b2.o_unit_start), 32'h0);
    chk("reset2 stall", 32'(b2.o_stall), 32'h0);
    chk("reset2 error", 32'(b2.o_error), 32'h0);
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < NV; i++) begin
      step();
      idle1();
      b1.i_req_valid     = tv[i].req_valid;
      b1.i_req_unit      = tv[i].unit;
      b1.i_req_rd        = tv[i].rd;
      b1.i_req_rd_is_int = tv[i].is_int;
      b1.i_flush         = tv[i].flush;
      b1.i_unit_valid    = tv[i].uvalid;
      b1.i_unit_result[tv[i].rl] = tv[i].res;
      @(negedge clk);
      chk_all1($sformatf("row%0d", i), tv[i].e_start, tv[i].e_stall, tv[i].e_wb, tv[i].e_err);
      if (tv[i].e_wb) begin
        chk($sformatf("row%0d wb_data", i), b1.o_wb_data, tv[i].e_data);
        chk($sformatf("row%0d wb_rd", i), 32'(b1.o_wb_rd), 32'(tv[i].e_rd));
        chk($sformatf("row%0d wb_is_int", i), 32'(b1.o_wb_is_int), 32'(tv[i].e_int));
      end
    end

    // Divide/sqrt unit answering 20 cycles after its start pulse
    for (int k = 0; k < 24; k++) begin
      step();
      idle1();
      if (k == 0) req1(2'd3, 5'd17, 1'b0);
      if (k == 21) begin
        b1.i_unit_valid = 4'b1000;
        b1.i_unit_result[3] = 32'h4049_0FDB;
      end
      @(negedge clk);
      chk_all1($sformatf("div k%0d", k), (k == 1) ? 4'b1000 : 4'b0000,
               k <= 21, k == 22, 1'b0);
      if (k == 22) begin
        chk("div wb_data", b1.o_wb_data, 32'h4049_0FDB);
        chk("div wb_rd", 32'(b1.o_wb_rd), 32'd17);
        chk("div wb_is_int", 32'(b1.o_wb_is_int), 32'd0);
      end
    end

    // Flush while waiting: drain the late result, no writeback
    for (int k = 0; k < 10; k++) begin
      step();
      idle1();
      if (k == 0) req1(2'd2, 5'd5, 1'b0);
      if (k == 3) b1.i_flush = 1'b1;
      if (k == 8) b1.i_unit_valid = 4'b0100;
      @(negedge clk);
      chk_all1($sformatf("drain k%0d", k), (k == 1) ? 4'b0100 : 4'b0000,
               k <= 8, 1'b0, 1'b0);
    end

    // Reset while waiting abandons the op; a late valid is ignored
    for (int k = 0; k < 9; k++) begin
      step();
      idle1();
      rst = (k == 3);
      if (k == 0) req1(2'd3, 5'd9, 1'b1);
      if (k == 5) b1.i_unit_valid = 4'b1000;
      @(negedge clk);
      if (k >= 4) begin
        chk_all1($sformatf("rstmid k%0d", k), 4'b0000, 1'b0, 1'b0, 1'b0);
      end
      if (k == 4) begin
        chk("rstmid wb_data", b1.o_wb_data, 32'h0);
        chk("rstmid wb_rd", 32'(b1.o_wb_rd), 32'h0);
        chk("rstmid wb_is_int", 32'(b1.o_wb_is_int), 32'h0);
      end
    end
    rst = 1'b0;

    // Watchdog: unit 0 never answers, timeout 8
    for (int k = 0; k < 12; k++) begin
      step();
      idle2();
      if (k == 0) begin
        b2.i_req_valid = 1'b1; b2.i_req_unit = 2'd0; b2.i_req_rd = 5'd4;
      end
      @(negedge clk);
      chk($sformatf("wdog k%0d stall", k), 32'(b2.o_stall), 32'(k <= 9));
      chk($sformatf("wdog k%0d error", k), 32'(b2.o_error), 32'(k == 10));
      chk($sformatf("wdog k%0d wb_valid", k), 32'(b2.o_wb_valid), 32'h0);
    end

    // Out-of-range unit index on the 3-unit instance
    for (int k = 0; k < 4; k++) begin
      step();
      idle2();
      if (k == 0) begin
        b2.i_req_valid = 1'b1; b2.i_req_unit = 2'd3; b2.i_req_rd = 5'd6;
      end
      @(negedge clk);
      chk($sformatf("badidx k%0d start", k), 32'(b2.o_unit_start), 32'h0);
      chk($sformatf("badidx k%0d stall", k), 32'(b2.o_stall), 32'(k == 0));
      chk($sformatf("badidx k%0d error", k), 32'(b2.o_error), 32'(k == 1));
      chk($sformatf("badidx k%0d wb_valid", k), 32'(b2.o_wb_valid), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
